// File: rtl/mult_mr_pkg.sv
// ============================================================================
// mult_mr_pkg : shared widths and types for the row-by-scalar multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_mr_pkg;

   localparam int ELEM_W = 8;
   localparam int N_ELEM = 5;
   localparam int ROW_W  = ELEM_W * N_ELEM;

   typedef logic signed [ELEM_W-1:0] elem_t;
   typedef logic        [ROW_W-1:0]  row_t;

endpackage

`default_nettype wire

// File: rtl/mult_mr_lane.sv
// ============================================================================
// mult_mr_lane : one signed element x scalar lane, wrapped result + overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_mr_lane
   import mult_mr_pkg::*;
(
   input  elem_t a,
   input  elem_t b,
   output elem_t prod_wrap,
   output logic  lane_ovf
);

   logic signed [2*ELEM_W-1:0] prod_full;
   logic        [ELEM_W:0]     prod_top;

   always_comb begin
      prod_full = a * b;
      prod_wrap = prod_full[ELEM_W-1:0];
      // Representable only when the upper bits are a pure sign extension of bit ELEM_W-1.
      prod_top  = prod_full[2*ELEM_W-1:ELEM_W-1];
      lane_ovf  = ~((&prod_top) | ~(|prod_top));
   end

endmodule

`default_nettype wire

// File: rtl/mult_mr.sv
// ============================================================================
// mult_mr : registered element-wise signed multiply of a packed row by a scalar
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_mr
   import mult_mr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ROW_W-1:0] m_1,
   input  logic [ELEM_W-1:0] n,
   output logic [ROW_W-1:0] m_out,
   output logic             ovf
);

   row_t              m_out_d, m_out_q;
   logic              ovf_d, ovf_q;
   logic [N_ELEM-1:0] lane_ovf;
   row_t              lane_res;

   genvar k;
   generate
      for (k = 0; k < N_ELEM; k++) begin : g_lane
         mult_mr_lane u_lane (
            .a         (m_1[k*ELEM_W +: ELEM_W]),
            .b         (n),
            .prod_wrap (lane_res[k*ELEM_W +: ELEM_W]),
            .lane_ovf  (lane_ovf[k])
         );
      end
   endgenerate

   always_comb begin
      m_out_d = lane_res;
      ovf_d   = |lane_ovf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         m_out_q <= m_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign m_out = m_out_q;
   assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_mr.sv
// ============================================================================
// tb_mult_mr : directed and randomized checks of mult_mr against an integer model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_mr;

   logic        clk;
   logic        rst;
   logic [39:0] m_1;
   logic [7:0]  n;
   logic [39:0] m_out;
   logic        ovf;

   int checks;
   int errors;

   mult_mr dut (
      .clk   (clk),
      .rst   (rst),
      .m_1   (m_1),
      .n     (n),
      .m_out (m_out),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer product per lane, low byte kept, range test for overflow.
   function automatic void model(input logic [39:0] row, input logic [7:0] s,
                                 output logic [39:0] exp_row, output logic exp_ovf);
      int a;
      int b;
      int p;
      exp_ovf = 1'b0;
      exp_row = '0;
      b = $signed(s);
      for (int k = 0; k < 5; k++) begin
         a = $signed(row[k*8 +: 8]);
         p = a * b;
         exp_row[k*8 +: 8] = p[7:0];
         if (p < -128 || p > 127) exp_ovf = 1'b1;
      end
   endfunction

   task automatic check(input string tag, input logic [39:0] exp_row, input logic exp_ovf);
      checks++;
      assert (m_out === exp_row) else begin
         errors++;
         $error("FAIL %s m_out: got %h expected %h", tag, m_out, exp_row);
      end
      checks++;
      assert (ovf === exp_ovf) else begin
         errors++;
         $error("FAIL %s ovf: got %b expected %b", tag, ovf, exp_ovf);
      end
   endtask

   // Drive on the falling edge, sample 1 ns after the following rising edge.
   task automatic apply(input logic [39:0] row, input logic [7:0] s);
      @(negedge clk);
      m_1 = row;
      n   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [39:0] row, input logic [7:0] s,
                           input logic [39:0] exp_row, input logic exp_ovf);
      apply(row, s);
      check(tag, exp_row, exp_ovf);
   endtask

   initial begin
      logic [39:0] r_row;
      logic [7:0]  r_s;
      logic [39:0] e_row;
      logic        e_ovf;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      m_1 = 'x;
      n   = 'x;

      #12;
      check("reset_hold", 40'h0, 1'b0);

      @(negedge clk);
      m_1 = 40'h0203040500;
      n   = 8'h03;
      rst = 1'b0;
      #1;
      check("post_release", 40'h0, 1'b0);
      @(posedge clk);
      #1;
      check("pos_no_ovf", 40'h06090C0F00, 1'b0);

      directed("mixed_sign", 40'h02FD04FB00, 8'hFD, 40'hFA09F40F00, 1'b0);
      directed("ovf_wrap",   40'h0A0B0C0D00, 8'h0B, 40'h6E79848F00, 1'b1);
      directed("ext_m128",   40'h8080800100, 8'h80, 40'h0000008000, 1'b1);
      directed("ext_p1",     40'h8080800100, 8'h01, 40'h8080800100, 1'b0);
      directed("neg_one",    40'h8000000000, 8'hFF, 40'h8000000000, 1'b1);
      directed("n_zero",     40'h7F80FF0155, 8'h00, 40'h0000000000, 1'b0);

      // Asynchronous reset between edges while ovf is high.
      directed("pre_areset", 40'h0A0B0C0D00, 8'h0B, 40'h6E79848F00, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 40'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      directed("after_reset", 40'h0203040500, 8'h03, 40'h06090C0F00, 1'b0);

      for (int i = 0; i < 200; i++) begin
         r_row = {$urandom, $urandom};
         r_s   = 8'($urandom);
         if (i % 8 == 0) r_s = 8'h80;
         model(r_row, r_s, e_row, e_ovf);
         apply(r_row, r_s);
         check("random", e_row, e_ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_mr.md
Name:
mult_mr

Overview:
- Element-wise signed multiply of one packed matrix row (5 lanes × 8-bit two's complement) by one signed 8-bit scalar.
- Part of the matrix coprocessor datapath; provides the matrix-by-real (scalar) operation.
- Result is registered: each lane is wrapped to 8 bits, and a single sticky-free overflow flag reports whether any lane left the signed 8-bit range.

Parameters:
- ELEM_W, 8: width of one signed element and of the scalar.
- N_ELEM, 5: number of lanes in the packed row.

Ports:
- clk, input, 1: system clock; rising edge active.
- rst, input, 1: asynchronous, active-high reset.
- m_1, input, ELEM_W*N_ELEM (40): packed signed row. Lane k occupies bits [8k+7:8k].
- n, input, ELEM_W (8): signed scalar multiplier.
- m_out, output, ELEM_W*N_ELEM (40): packed signed result, same lane layout as m_1.
- ovf, output, 1: high when at least one lane's exact product was not representable in ELEM_W signed bits.

Behaviour:
- Reset: while rst=1, m_out=0 and ovf=0 immediately (asynchronous), regardless of inputs. Registers load on the first rising clk edge after rst deasserts.
- No enable and no handshake. Each rising edge (rst=0) samples m_1 and n.
- Latency:
  - m_out/ovf reflect the inputs sampled one edge earlier.
  - Throughput is one row per cycle.
  - Outputs hold between edges.
- Per lane k:
  - p_k = signed(m_1 lane k) × signed(n), computed exactly at 2*ELEM_W (16) bits signed.
  - m_out lane k = p_k[7:0], i.e. two's-complement wrap with no saturation.
  - lane_ovf_k = 1 iff p_k < -128 or p_k > 127 (equivalently, p_k[15:7] not all equal).
- ovf = OR of lane_ovf_k over all N_ELEM lanes. It is registered in the same cycle as m_out and is not sticky; it is recomputed every cycle.
- All lanes are computed, including lane 0. There is no don't-care lane; a zero lane yields zero.
- Corner values:
  - (-128)×(-128) = 16384 → lane 0x00, ovf=1.
  - (-128)×(-1) = 128 → lane 0x80, ovf=1.
  - (-128)×1 → 0x80, ovf=0.
  - n=0 → all lanes 0, ovf=0.
- Reset mid-operation: outputs clear asynchronously; the in-flight result is discarded.
- X/unknown inputs are not filtered; rst has priority.

Decomposition:
- Shared package: ELEM_W, N_ELEM, ROW_W = ELEM_W*N_ELEM, a typedef for a signed element, and a typedef for the packed row.
- One sub-module, mult_mr_lane: combinational signed ELEM_W×ELEM_W multiply, producing an 8-bit wrapped result and lane_ovf. It is instantiated N_ELEM times via generate.
- The top module holds the output registers and the ovf OR-reduction.

Test Plan:
- Reset: hold rst=1 for 10 ns with clk toggling and inputs X → m_out=0, ovf=0. Release rst; outputs stay 0 until the first valid sample.
- Positive, no overflow: m_1=0x0203040500, n=0x03 → after 1 edge, m_out=0x06090C0F00 ([6,9,12,15,0]), ovf=0.
- Mixed sign: m_1=0x02FD04FB00 ([2,-3,4,-5,0]), n=0xFD (-3) → m_out=0xFA09F40F00 ([-6,9,-12,15,0]), ovf=0.
- Overflow wrap: m_1=0x0A0B0C0D00 ([10,11,12,13,0]), n=0x0B (11) → m_out=0x6E79848F00, ovf=1 (lanes with 132 and 143 overflow; 110 and 121 do not).
- Extremes: m_1=0x8080800100 with n=0x80 (-128) → m_out=0x0000008000, ovf=1. Then the same m_1 with n=0x01 → m_out=0x8080800100, ovf=0, confirming ovf clears in the next cycle.
- Async reset mid-stream: assert rst between clk edges while ovf=1 → m_out=0 and ovf=0 immediately, without waiting for a clk edge.
